debug_seg_scan: RTL and testbench

Scans a 16-bit debug word onto four time-multiplexed seven-segment digits, one hex nibble per digit. It sits directly downstream of the switch-selected debug LED multiplexer and consumes its 16-bit output. It adds a display hold, per-nibble change flags shown on the decimal points, and optional leading-zero blanking. All outputs are registered and active-low to match the board's common-anode displays.

---
 rtl/debug_seg_scan_if.sv | 22 ++
 rtl/debug_seg_scan.sv | 107 ++++++++++
 tb/tb_debug_seg_scan.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/debug_seg_scan_if.sv
// Bundle carrying the debug word, the display controls and the registered
// common-anode display outputs of debug_seg_scan.
interface debug_seg_scan_if;
    logic [15:0] data;
    logic        hold;
    logic        clr_chg;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  chg;

    modport master (
        output data, hold, clr_chg, blank_lz,
        input  an, seg, dp, chg
    );

    modport slave (
        input  data, hold, clr_chg, blank_lz,
        output an, seg, dp, chg
    );
endinterface

// File: rtl/debug_seg_scan.sv
// Time-multiplexed four-digit hex display of a 16-bit debug word, with
// display hold, sticky per-nibble change flags on the decimal points and
// optional leading-zero blanking. All display outputs are registered, active-low.
module debug_seg_scan #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst,
    debug_seg_scan_if.slave  bus
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [1:0]    idx_nx;
    logic [15:0]   disp;
    logic [3:0]    chg_q;
    logic [3:0]    chg_nx;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q;
    logic          tick;
    logic [3:0]    nib;
    logic          blank;
    logic [6:0]    seg_nx;

    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        tick   = (cnt == CNT_LAST);
        idx_nx = idx + 2'd1;
        nib    = disp[{idx_nx, 2'b00} +: 4];
        // A digit is blanked only when it and every more significant nibble are zero.
        case (idx_nx)
            2'd1:    blank = bus.blank_lz && (disp[15:4] == '0);
            2'd2:    blank = bus.blank_lz && (disp[15:8] == '0);
            2'd3:    blank = bus.blank_lz && (disp[15:12] == '0);
            default: blank = 1'b0;
        endcase
        seg_nx = blank ? '1 : hex_decode(nib);
    end

    // Clear first, then set: a change seen in the clearing cycle still flags.
    always_comb begin
        chg_nx = bus.clr_chg ? '0 : chg_q;
        if (!bus.hold) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (bus.data[4*i +: 4] != disp[4*i +: 4]) begin
                    chg_nx[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            idx   <= 2'd3;
            disp  <= '0;
            chg_q <= '0;
            an_q  <= '1;
            seg_q <= '1;
            dp_q  <= 1'b1;
        end else begin
            cnt   <= tick ? '0 : cnt + 1'b1;
            chg_q <= chg_nx;
            if (!bus.hold) begin
                disp <= bus.data;
            end
            if (tick) begin
                idx   <= idx_nx;
                an_q  <= ~(4'b0001 << idx_nx);
                seg_q <= seg_nx;
                dp_q  <= ~chg_q[idx_nx];
            end
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;
    assign bus.chg = chg_q;

endmodule

// File: tb/tb_debug_seg_scan.sv
// Self-checking bench for debug_seg_scan: directed table and sequences plus
// randomized traffic, all compared against a frame-arithmetic reference model.
module tb_debug_seg_scan;

    localparam int unsigned SD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    debug_seg_scan_if bif ();

    debug_seg_scan #(.SCAN_DIV(SD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [6:0] hex_seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: tick k occurs on edge k*SD after reset release and lights
    // digit (k-1) mod 4, using the word and flags held just before that edge.
    int unsigned m_edges = 0;
    logic [15:0] m_disp = '0;
    logic [3:0]  m_chg  = '0;
    logic [3:0]  m_an   = '1;
    logic [6:0]  m_seg  = '1;
    logic        m_dp   = 1'b1;
    logic [15:0] od;
    logic [3:0]  oc, nc, on;
    int unsigned k;

    always @(posedge clk) begin
        if (rst) begin
            m_edges = 0; m_disp = '0; m_chg = '0;
            m_an = '1; m_seg = '1; m_dp = 1'b1;
        end else begin
            od = m_disp;
            oc = m_chg;
            m_edges++;
            if (m_edges % SD == 0) begin
                k = (m_edges / SD - 1) % 4;
                m_an = '1;
                m_an[k] = 1'b0;
                m_dp = ~oc[k];
                on = 4'((od >> (4 * k)) & 16'hF);
                if (bif.blank_lz && k > 0 && (od >> (4 * k)) == 16'h0)
                    m_seg = 7'h7F;
                else
                    m_seg = hex_seg[on];
            end
            nc = bif.clr_chg ? 4'h0 : oc;
            if (!bif.hold) begin
                for (int i = 0; i < 4; i++)
                    if (((bif.data >> (4 * i)) & 16'hF) != ((od >> (4 * i)) & 16'hF)) nc[i] = 1'b1;
                m_disp = bif.data;
            end
            m_chg = nc;
        end
    end

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check("model{an,seg,dp,chg}", {bif.an, bif.seg, bif.dp, bif.chg},
              {m_an, m_seg, m_dp, m_chg});
    endtask

    task automatic steps(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    task automatic wait_an(input logic [3:0] target, input string nm);
        int unsigned n = 0;
        while (bif.an !== target && n < 4 * SD + 4) begin
            step();
            n++;
        end
        if (bif.an !== target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: timeout waiting an, got %h, expected %h", nm, bif.an, target);
        end
    endtask

    typedef struct {
        logic [15:0] data;
        logic        blank;
        logic [3:0]  an;
        logic [6:0]  seg;
    } vec_t;

    vec_t vecs [13];

    initial begin
        vecs = '{
            '{16'h1A2F, 1'b0, 4'hE, 7'h0E}, '{16'h1A2F, 1'b0, 4'hD, 7'h24},
            '{16'h1A2F, 1'b0, 4'hB, 7'h08}, '{16'h1A2F, 1'b0, 4'h7, 7'h79},
            '{16'h0030, 1'b1, 4'h7, 7'h7F}, '{16'h0030, 1'b1, 4'hB, 7'h7F},
            '{16'h0030, 1'b1, 4'hD, 7'h30}, '{16'h0030, 1'b1, 4'hE, 7'h40},
            '{16'h0000, 1'b1, 4'h7, 7'h7F}, '{16'h0000, 1'b1, 4'hB, 7'h7F},
            '{16'h0000, 1'b1, 4'hD, 7'h7F}, '{16'h0000, 1'b1, 4'hE, 7'h40},
            '{16'h0000, 1'b0, 4'hD, 7'h40}
        };
        bif.data = '0; bif.hold = 1'b0; bif.clr_chg = 1'b0; bif.blank_lz = 1'b0;

        // Reset and first tick.
        rst = 1'b1;
        steps(3);
        check("reset an", 16'(bif.an), 16'hF);
        check("reset seg", 16'(bif.seg), 16'h7F);
        check("reset dp", 16'(bif.dp), 16'h1);
        check("reset chg", 16'(bif.chg), 16'h0);
        rst = 1'b0;
        for (int unsigned i = 1; i < SD; i++) begin
            step();
            check("pre-tick an", 16'(bif.an), 16'hF);
        end
        step();
        check("first tick an", 16'(bif.an), 16'hE);

        // Table-driven digit contents.
        foreach (vecs[i]) begin
            bif.data = vecs[i].data;
            bif.blank_lz = vecs[i].blank;
            bif.clr_chg = 1'b1;
            step();
            bif.clr_chg = 1'b0;
            steps(4 * SD + 1);
            wait_an(vecs[i].an, "table an");
            check("table seg", 16'(bif.seg), 16'(vecs[i].seg));
        end
        bif.blank_lz = 1'b0;

        // Hold freezes the display; release flags every differing nibble.
        bif.data = 16'h1234;
        steps(2);
        bif.clr_chg = 1'b1;
        step();
        bif.clr_chg = 1'b0;
        bif.hold = 1'b1;
        bif.data = 16'hABCD;
        steps(4 * SD + 2);
        check("hold chg", 16'(bif.chg), 16'h0);
        wait_an(4'hE, "hold an");
        check("hold seg d0", 16'(bif.seg), 16'h19);
        wait_an(4'h7, "hold an3");
        check("hold seg d3", 16'(bif.seg), 16'h79);
        bif.hold = 1'b0;
        step();
        check("release chg", 16'(bif.chg), 16'hF);
        steps(4 * SD + 1);
        for (int unsigned i = 0; i < 4 * SD; i++) begin
            step();
            check("release dp", 16'(bif.dp), 16'h0);
        end

        // Change flags and set-over-clear.
        bif.data = 16'h0000;
        steps(2);
        bif.clr_chg = 1'b1;
        step();
        bif.clr_chg = 1'b0;
        check("chg cleared", 16'(bif.chg), 16'h0);
        bif.data = 16'h0050;
        step();
        check("chg 0050", 16'(bif.chg), 16'h2);
        steps(4 * SD + 1);
        for (int unsigned i = 0; i < 4 * SD; i++) begin
            step();
            check("dp on digit1 only", 16'(bif.dp), (bif.an == 4'hD) ? 16'h0 : 16'h1);
        end
        bif.clr_chg = 1'b1;
        bif.data = 16'h0150;
        step();
        bif.clr_chg = 1'b0;
        check("set wins over clr", 16'(bif.chg), 16'h4);

        // Reset mid-scan, two edges into digit 2's slot.
        wait_an(4'hB, "midscan an");
        steps(2);
        rst = 1'b1;
        step();
        check("midscan an", 16'(bif.an), 16'hF);
        check("midscan chg", 16'(bif.chg), 16'h0);
        rst = 1'b0;
        bif.data = 16'h0000;
        for (int unsigned i = 1; i < SD; i++) begin
            step();
            check("midscan pre-tick", 16'(bif.an), 16'hF);
        end
        step();
        check("midscan first tick", 16'(bif.an), 16'hE);
        check("midscan seg", 16'(bif.seg), 16'h40);

        // Randomized traffic against the model.
        for (int unsigned i = 0; i < 800; i++) begin
            if ($urandom_range(3) == 0) bif.data[4 * $urandom_range(3) +: 4] = 4'($urandom);
            if ($urandom_range(15) == 0) bif.data = '0;
            bif.hold = ($urandom_range(7) == 0);
            bif.clr_chg = ($urandom_range(11) == 0);
            if ($urandom_range(31) == 0) bif.blank_lz = ~bif.blank_lz;
            rst = ($urandom_range(199) == 0);
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
